// File: rtl/booth_radix4_mul.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier digit per clock,
// signed or unsigned operands, full 2*WIDTH-bit registered product. WIDTH must be even and >= 4.
module booth_radix4_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  // Handshake: start is only taken in IDLE (busy=0); a, b and sgn are captured on
  // that edge. busy stays high through RUN and DONE; done is a single-cycle pulse
  // during which product already holds the new result. start while busy is dropped.

  localparam int N  = WIDTH / 2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int HW = WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HW-1:0]        hi_q, hi_d;
  logic [EW-1:0]        lo_q, lo_d;
  logic                 bm1_q, bm1_d;
  logic [HW-1:0]        mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [HW-1:0]        a_ext;
  logic [EW-1:0]        b_ext;
  logic [2:0]           triplet;
  logic [HW-1:0]        pp;
  logic [HW-1:0]        sum;
  logic [HW+EW-1:0]     shifted;

  assign a_ext = sgn ? {{3{a[WIDTH-1]}}, a} : {3'b000, a};
  assign b_ext = sgn ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // The low multiplier bits ride in lo_q and shift out as product bits shift in.
  assign triplet = {lo_q[1:0], bm1_q};

  always_comb begin
    pp = '0;
    case (triplet)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign sum     = hi_q + pp;
  assign shifted = {{2{sum[HW-1]}}, sum, lo_q[EW-1:2]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    bm1_d     = bm1_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = b_ext;
          bm1_d   = 1'b0;
          mcand_d = a_ext;
        end
      end
      S_RUN: begin
        hi_d  = shifted[HW+EW-1:EW];
        lo_d  = shifted[EW-1:0];
        bm1_d = lo_q[1];
        if (cnt_q == LAST) begin
          state_d   = S_DONE;
          product_d = shifted[2*WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      bm1_q     <= 1'b0;
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      bm1_q     <= bm1_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule
